// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode from the UART receiver, drives the ALU, and hands the result to the transmitter.
// Optional inter-byte timeout recovery is compiled in when UART_ALU_SEQ_TIMEOUT_EN is defined.
module uart_alu_sequencer #(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned NB_OP         = 6,
  parameter int unsigned NB_TIMEOUT    = 12,
  parameter int unsigned TIMEOUT_TICKS = 1760
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_rx_frame_valid,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_error
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic               timeout;

`ifdef UART_ALU_SEQ_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;

  // A byte in the same cycle as the final tick takes precedence over the timeout.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (((state_q != WAIT_B) && (state_q != WAIT_OP)) || i_rx_done) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (cnt_q == NB_TIMEOUT'(TIMEOUT_TICKS - 1)) begin
        timeout = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = i_tick;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      WAIT_A, WAIT_B, WAIT_OP: begin
        if (i_rx_done) begin
          if (!i_rx_frame_valid) begin
            error_d = 1'b1;
            state_d = WAIT_A;
          end else if (state_q == WAIT_A) begin
            alu_a_d = i_rx_data;
            state_d = WAIT_B;
          end else if (state_q == WAIT_B) begin
            alu_b_d = i_rx_data;
            state_d = WAIT_OP;
          end else begin
            alu_op_d = i_rx_data[NB_OP-1:0];
            state_d  = EXEC;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        error_d    = i_rx_done;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        error_d = i_rx_done;
        // A done pulse coinciding with our own start pulse belongs to an older frame.
        if (i_tx_done && !tx_start_q) begin
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
    busy_d = (state_d == EXEC) || (state_d == WAIT_TX);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: command-level reference model plus directed literal checks.
// Expectations follow UART_ALU_SEQ_TIMEOUT_EN exactly as the design does.
module tb_uart_alu_sequencer;

  localparam int unsigned TICKS = 1760;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk, rst_n, tick, rx_done, rx_valid, tx_done;
  logic [7:0] rx_data, alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_error;

  int checks = 0;
  int errors = 0;

  uart_alu_sequencer #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(12), .TIMEOUT_TICKS(TICKS)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .i_rx_frame_valid(rx_valid),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(alu_result), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_done(tx_done), .o_busy(o_busy), .o_error(o_error)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: tracks how many command bytes are held and whether a result is in flight.
  int         n_got = 0;
  int         ticks = 0;
  bit         m_busy = 0;
  bit         exec_pend = 0;
  bit         prev_start = 0;
  logic [7:0] ea = '0, eb = '0, etx = '0;
  logic [5:0] eop = '0;
  bit         estart = 0, eerr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_got = 0; ticks = 0; m_busy = 0; exec_pend = 0;
      ea = '0; eb = '0; eop = '0; etx = '0; estart = 0; eerr = 0;
    end else begin
      prev_start = estart;
      estart     = 0;
      eerr       = 0;
      if (m_busy) begin
        if (rx_done) eerr = 1;
        if (exec_pend) begin
          etx = alu(ea, eb, eop); estart = 1; exec_pend = 0;
        end else if (tx_done && !prev_start) begin
          m_busy = 0;
        end
      end else if (rx_done) begin
        ticks = 0;
        if (!rx_valid) begin
          eerr = 1; n_got = 0;
        end else begin
          if (n_got == 0) ea = rx_data;
          else if (n_got == 1) eb = rx_data;
          else eop = rx_data[5:0];
          n_got++;
          if (n_got == 3) begin n_got = 0; m_busy = 1; exec_pend = 1; end
        end
      end else if (TIMEOUT_ON && n_got > 0 && tick) begin
        ticks++;
        if (ticks == int'(TICKS)) begin eerr = 1; n_got = 0; ticks = 0; end
      end
      if (n_got == 0) ticks = 0;
    end
  end

  always @(negedge clk) begin
    chk("m_alu_a", o_alu_a, ea);
    chk("m_alu_b", o_alu_b, eb);
    chk("m_alu_op", o_alu_op, eop);
    chk("m_tx_data", o_tx_data, etx);
    chk("m_tx_start", o_tx_start, estart);
    chk("m_busy", o_busy, m_busy);
    chk("m_error", o_error, eerr);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic v);
    rx_data = d; rx_valid = v; rx_done = 1'b1;
    cyc();
    rx_done = 1'b0; rx_valid = 1'b1;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1; cyc(); tx_done = 1'b0;
  endtask

  task automatic drain(input logic [7:0] exp_tx);
    int n = 0;
    while (!o_tx_start && n < 10) begin cyc(); n++; end
    chk("drain_start_seen", o_tx_start, 1'b1);
    chk("drain_tx_data", o_tx_data, exp_tx);
    repeat (2) cyc();
    pulse_tx_done();
    chk("drain_busy_clear", o_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst_n = 1; tick = 0; rx_done = 0; rx_valid = 1; rx_data = '0; tx_done = 0;
    #2 rst_n = 0;
    repeat (2) cyc();
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_tx_start, 0);
    chk("rst_tx", o_tx_data, 0);
    rst_n = 1;
    cyc();

    // ADD, with a stray tx_done during the start pulse
    send(8'h05, 1); send(8'h03, 1); send(8'h20, 1);
    chk("add_a", o_alu_a, 8'h05);
    chk("add_b", o_alu_b, 8'h03);
    chk("add_op", o_alu_op, 6'h20);
    chk("add_busy_exec", o_busy, 1);
    chk("add_no_start_yet", o_tx_start, 0);
    cyc();
    chk("add_start", o_tx_start, 1);
    chk("add_tx", o_tx_data, 8'h08);
    pulse_tx_done();
    chk("add_start_once", o_tx_start, 0);
    chk("add_busy_held", o_busy, 1);
    cyc();
    pulse_tx_done();
    chk("add_busy_done", o_busy, 0);

    // Bad frame restarts the command; old operands kept
    send(8'h05, 1); send(8'h03, 0);
    chk("bad_error", o_error, 1);
    chk("bad_b_kept", o_alu_b, 8'h03);
    send(8'h0A, 1); send(8'h02, 1); send(8'h22, 1);
    chk("sub_a", o_alu_a, 8'h0A);
    drain(8'h08);

    // Overrun in WAIT_TX
    send(8'h0A, 1); send(8'h02, 1); send(8'h24, 1);
    cyc(); cyc();
    send(8'hFF, 1);
    chk("ovr_error", o_error, 1);
    chk("ovr_tx_kept", o_tx_data, 8'h02);
    chk("ovr_no_start", o_tx_start, 0);
    chk("ovr_busy", o_busy, 1);
    pulse_tx_done();
    chk("ovr_busy_done", o_busy, 0);

    // Byte during EXEC dropped; command still completes
    send(8'h03, 1); send(8'h04, 1); send(8'h20, 1);
    send(8'h55, 1);
    chk("exec_drop_error", o_error, 1);
    chk("exec_drop_start", o_tx_start, 1);
    chk("exec_drop_tx", o_tx_data, 8'h07);
    cyc();
    pulse_tx_done();

    // rx_done and tx_done together in WAIT_TX
    send(8'h01, 1); send(8'h01, 1); send(8'h20, 1);
    cyc(); cyc();
    tx_done = 1'b1; send(8'h33, 1); tx_done = 1'b0;
    chk("both_error", o_error, 1);
    chk("both_idle", o_busy, 0);

    // Byte coinciding with the final timeout tick wins
    send(8'h05, 1);
    tick = 1'b1;
    repeat (TICKS - 1) cyc();
    send(8'h06, 1);
    tick = 1'b0;
    chk("race_no_error", o_error, 0);
    chk("race_b", o_alu_b, 8'h06);
    send(8'h26, 1);
    drain(8'h03);

    // Full silence of TICKS ticks after operand A
    send(8'h05, 1);
    tick = 1'b1;
    repeat (TICKS) cyc();
    tick = 1'b0;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
    chk("tmo_error", o_error, 1);
    send(8'h07, 1);
    chk("tmo_a", o_alu_a, 8'h07);
    send(8'h03, 1); send(8'h20, 1);
    drain(8'h0A);
`else
    chk("notmo_error", o_error, 0);
    send(8'h07, 1);
    chk("notmo_b", o_alu_b, 8'h07);
    send(8'h20, 1);
    drain(8'h0C);
`endif

    // Reset mid-command, then opcode byte with upper bits set
    send(8'h05, 1); send(8'h03, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_a", o_alu_a, 0);
    chk("mid_rst_b", o_alu_b, 0);
    chk("mid_rst_tx", o_tx_data, 0);
    chk("mid_rst_busy", o_busy, 0);
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    send(8'h01, 1); send(8'h02, 1); send(8'hE0, 1);
    chk("post_rst_op", o_alu_op, 6'h20);
    drain(8'h03);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
